// File: rtl/i2c_xfer_sched_if.sv
// Core-side bus between the transfer scheduler and the i2c_bridge core.
// master = scheduler (drives control/data), slave = core (returns status/read data).
interface i2c_xfer_sched_if;
  logic [7:0]  i2c_con1;
  logic [7:0]  i2c_con2;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [7:0]  i2c_stat;

  modport master (
    output i2c_con1,
    output i2c_con2,
    output Din,
    input  Dout,
    input  i2c_stat
  );

  modport slave (
    input  i2c_con1,
    input  i2c_con2,
    input  Din,
    output Dout,
    output i2c_stat
  );
endinterface

// File: rtl/i2c_xfer_sched.sv
// Round-robin scheduler that shares one i2c_bridge core between two requesters,
// sequencing con1/con2/Din, watching i2c_stat and recovering the core on timeout.
module i2c_xfer_sched #(
  parameter int TMO_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           clk_sel,
  input  logic [1:0]           req,
  input  logic [1:0]           req_rw,
  input  logic [13:0]          req_addr,
  input  logic [3:0]           req_cnt,
  input  logic [63:0]          req_wdata,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic [2:0]           dbg_state,
  i2c_xfer_sched_if.master     core
);

  // Requester handshake: req[n] is a level held until done[n]; gnt[n] is held from
  // LOAD through COMPLETE; done[n] is a single-cycle pulse and err/rdata are valid with it.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_COMPLETE  = 3'd5,
    S_DRAIN     = 3'd6,
    S_RECOVER   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [7:0]         con2_q, con2_d;
  logic [31:0]        din_q, din_d;
  logic [1:0]         cc_q, cc_d;
  logic [1:0]         ff_q, ff_d;
  logic               rw_q, rw_d;
  logic               rr_q, rr_d;
  logic               e_q, e_d;
  logic               r_q, r_d;
  logic               da_q, da_d;
  logic               rec_done_q, rec_done_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;

  logic               tmo;
  logic               win_idx;
  logic [31:0]        rd_mask;
  logic [TMO_W-1:0]   cnt_inc;
  logic               unused_stat;

  assign unused_stat = ^core.i2c_stat[7:3];
  assign tmo         = (cnt_q == {TMO_W{1'b1}});
  assign cnt_inc     = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};

  // rr_q remembers the last granted requester; on contention the other one wins.
  always_comb begin
    if (req == 2'b11) win_idx = ~rr_q;
    else              win_idx = req[1];
  end

  always_comb begin
    case (cc_q)
      2'd0:    rd_mask = 32'h0000_00ff;
      2'd1:    rd_mask = 32'h0000_ffff;
      2'd2:    rd_mask = 32'h00ff_ffff;
      default: rd_mask = 32'hffff_ffff;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    err_d      = err_q;
    rdata_d    = rdata_q;
    con2_d     = con2_q;
    din_d      = din_q;
    cc_d       = cc_q;
    ff_d       = ff_q;
    rw_d       = rw_q;
    rr_d       = rr_q;
    rec_done_d = rec_done_q;
    cnt_d      = cnt_q;
    da_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = win_idx ? 2'b10 : 2'b01;
          rw_d    = win_idx ? req_rw[1] : req_rw[0];
          con2_d  = win_idx ? {req_rw[1], req_addr[13:7]} : {req_rw[0], req_addr[6:0]};
          din_d   = win_idx ? req_wdata[63:32] : req_wdata[31:0];
          cc_d    = win_idx ? req_cnt[3:2] : req_cnt[1:0];
          ff_d    = clk_sel;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tmo) begin
          rec_done_d = 1'b1;
          state_d    = S_RECOVER;
        end else begin
          cnt_d = cnt_inc;
          if (core.i2c_stat[0]) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tmo) begin
          rec_done_d = 1'b1;
          state_d    = S_RECOVER;
        end else begin
          cnt_d = cnt_inc;
          if (core.i2c_stat[1]) begin
            err_d = core.i2c_stat[2];
            if (rw_q && !core.i2c_stat[2]) rdata_d = core.Dout & rd_mask;
            state_d = S_COMPLETE;
          end
        end
      end
      S_COMPLETE: begin
        done_d  = gnt_q;
        gnt_d   = 2'b00;
        rr_d    = gnt_q[1];
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // done was already returned, so a stuck xfer-done only needs a core reset.
        if (tmo) begin
          rec_done_d = 1'b0;
          state_d    = S_RECOVER;
        end else begin
          cnt_d = cnt_inc;
          if (!core.i2c_stat[1]) state_d = S_IDLE;
        end
      end
      S_RECOVER: begin
        if (rec_done_q) begin
          done_d = gnt_q;
          err_d  = 1'b1;
          gnt_d  = 2'b00;
          rr_d   = gnt_q[1];
        end
        rec_done_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Enable and core-reset bits follow the state being entered so they line up with it.
    e_d = (state_d == S_START) || (state_d == S_WAIT_BUSY) || (state_d == S_WAIT_DONE);
    r_d = (state_d != S_RECOVER);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      con2_q     <= 8'h00;
      din_q      <= 32'h0;
      cc_q       <= 2'b00;
      ff_q       <= 2'b00;
      rw_q       <= 1'b0;
      rr_q       <= 1'b1;
      e_q        <= 1'b0;
      r_q        <= 1'b0;
      da_q       <= 1'b0;
      rec_done_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      con2_q     <= con2_d;
      din_q      <= din_d;
      cc_q       <= cc_d;
      ff_q       <= ff_d;
      rw_q       <= rw_d;
      rr_q       <= rr_d;
      e_q        <= e_d;
      r_q        <= r_d;
      da_q       <= da_d;
      rec_done_q <= rec_done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign dbg_state     = state_q;
  assign core.i2c_con1 = {ff_q, 1'b0, da_q, cc_q, e_q, r_q};
  assign core.i2c_con2 = con2_q;
  assign core.Din      = din_q;

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Directed bench for i2c_xfer_sched: vector table of single transfers plus
// hand-written sequences for reset, round-robin, NACK and timeout recovery.
module tb_i2c_xfer_sched;

  localparam int          TMO_W        = 4;
  localparam logic [2:0]  ST_IDLE      = 3'd0;
  localparam logic [2:0]  ST_WAIT_DONE = 3'd4;
  localparam logic [7:0]  STAT_JUNK    = 8'hA8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  clk_sel;
  logic [1:0]  req;
  logic [1:0]  req_rw;
  logic [13:0] req_addr;
  logic [3:0]  req_cnt;
  logic [63:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic [2:0]  dbg_state;

  i2c_xfer_sched_if bus ();

  i2c_xfer_sched #(.TMO_W(TMO_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clk_sel   (clk_sel),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_cnt   (req_cnt),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .dbg_state (dbg_state),
    .core      (bus)
  );

  // clock
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  req;
    logic        rw;
    logic [6:0]  addr;
    logic [1:0]  cnt;
    logic [31:0] wdata;
    logic [1:0]  csel;
    logic        nack;
    logic [31:0] dout;
    logic [7:0]  e_con1;
    logic [7:0]  e_con2;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[7];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // core model knobs
  bit          busy_ok  = 1'b1;
  int          busy_dly = 1;
  int          done_dly = 2;
  logic        nack_m   = 1'b0;
  logic [31:0] dout_m   = 32'h0;
  int          e_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic core_step();
    if (bus.i2c_con1[1]) begin
      e_cnt++;
      if (busy_ok && e_cnt == busy_dly) bus.i2c_stat[0] = 1'b1;
      if (busy_ok && e_cnt == busy_dly + done_dly) begin
        bus.i2c_stat[1] = 1'b1;
        bus.i2c_stat[2] = nack_m;
        bus.Dout        = dout_m;
      end
    end else begin
      e_cnt        = 0;
      bus.i2c_stat = STAT_JUNK;
    end
  endtask

  task automatic load_req(input int n, input logic rw, input logic [6:0] a,
                          input logic [1:0] c, input logic [31:0] w);
    req_rw[n]           = rw;
    req_addr[7*n +: 7]  = a;
    req_cnt[2*n +: 2]   = c;
    req_wdata[32*n +: 32] = w;
  endtask

  // Runs one transfer from IDLE back to IDLE; observes start-cycle outputs and the done pulse.
  task automatic run_xfer(input bit hold, output logic [1:0] g, output logic [7:0] c1,
                          output logic [7:0] c2, output logic [31:0] din,
                          output logic [1:0] dn, output logic er, output logic [31:0] rd,
                          output bit ok);
    bit seen_start = 1'b0;
    g  = 2'bxx; c1 = 8'hxx; c2 = 8'hxx; din = 32'hx;
    dn = 2'b00; er = 1'bx; rd = 32'hx; ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge CLK);
      if (!seen_start && bus.i2c_con1[1]) begin
        seen_start = 1'b1;
        g   = gnt;
        c1  = bus.i2c_con1;
        c2  = bus.i2c_con2;
        din = bus.Din;
      end
      if (done != 2'b00) begin
        dn = done;
        er = err;
        rd = rdata;
        if (!hold) req = req & ~done;
      end else if (dn != 2'b00 && dbg_state == ST_IDLE) begin
        ok = 1'b1;
        break;
      end
      core_step();
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int idx = v.req[1] ? 1 : 0;
    logic [1:0] g, dn;
    logic [7:0] c1, c2;
    logic [31:0] din, rd;
    logic er;
    bit ok;
    load_req(idx, v.rw, v.addr, v.cnt, v.wdata);
    load_req(1 - idx, ~v.rw, ~v.addr, ~v.cnt, ~v.wdata);
    clk_sel = v.csel;
    nack_m  = v.nack;
    dout_m  = v.dout;
    req     = v.req;
    run_xfer(1'b0, g, c1, c2, din, dn, er, rd, ok);
    req = 2'b00;
    check($sformatf("%s completed", tag), {31'h0, ok}, 32'h1);
    check($sformatf("%s gnt", tag), {30'h0, g}, {30'h0, v.req});
    check($sformatf("%s con1", tag), {24'h0, c1}, {24'h0, v.e_con1});
    check($sformatf("%s con2", tag), {24'h0, c2}, {24'h0, v.e_con2});
    check($sformatf("%s Din", tag), din, v.wdata);
    check($sformatf("%s done", tag), {30'h0, dn}, {30'h0, v.req});
    check($sformatf("%s err", tag), {31'h0, er}, {31'h0, v.e_err});
    check($sformatf("%s rdata", tag), rd, v.e_rdata);
  endtask

  initial begin
    logic [1:0]  g, dn;
    logic [7:0]  c1, c2;
    logic [31:0] din, rd;
    logic        er;
    bit          ok, got, found;
    int          ecount;

    // req rw addr cnt wdata csel nack dout -> con1 con2 err rdata
    vt[0] = '{2'b01, 1'b0, 7'h65, 2'd3, 32'h0000_feab, 2'd3, 1'b0, 32'h0,         8'hDF, 8'h65, 1'b0, 32'h0};
    vt[1] = '{2'b01, 1'b1, 7'h50, 2'd1, 32'h0,         2'd0, 1'b0, 32'h1234_5678, 8'h17, 8'hD0, 1'b0, 32'h0000_5678};
    vt[2] = '{2'b10, 1'b0, 7'h2a, 2'd0, 32'ha5a5_0001, 2'd1, 1'b0, 32'hffff_ffff, 8'h53, 8'h2A, 1'b0, 32'h0000_5678};
    vt[3] = '{2'b10, 1'b1, 7'h11, 2'd2, 32'h0,         2'd2, 1'b1, 32'hdead_beef, 8'h9B, 8'h91, 1'b1, 32'h0000_5678};
    vt[4] = '{2'b10, 1'b1, 7'h11, 2'd2, 32'h0,         2'd2, 1'b0, 32'hdead_beef, 8'h9B, 8'h91, 1'b0, 32'h00ad_beef};
    vt[5] = '{2'b01, 1'b1, 7'h7f, 2'd3, 32'h0,         2'd0, 1'b0, 32'hcafe_f00d, 8'h1F, 8'hFF, 1'b0, 32'hcafe_f00d};
    vt[6] = '{2'b10, 1'b1, 7'h0c, 2'd0, 32'h0,         2'd2, 1'b0, 32'h9988_7766, 8'h93, 8'h8C, 1'b0, 32'h0000_0066};

    // reset
    RST = 1'b1; clk_sel = 2'b00; req = 2'b00; req_rw = 2'b00;
    req_addr = '0; req_cnt = '0; req_wdata = '0;
    bus.Dout = 32'h0; bus.i2c_stat = STAT_JUNK;
    repeat (3) @(negedge CLK);
    check("rst gnt", {30'h0, gnt}, 32'h0);
    check("rst done", {30'h0, done}, 32'h0);
    check("rst err", {31'h0, err}, 32'h0);
    check("rst rdata", rdata, 32'h0);
    check("rst con1", {24'h0, bus.i2c_con1}, 32'h0);
    check("rst con2", {24'h0, bus.i2c_con2}, 32'h0);
    check("rst Din", bus.Din, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle con1", {24'h0, bus.i2c_con1}, 32'h11);
    check("idle state", {29'h0, dbg_state}, {29'h0, ST_IDLE});

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // reset asserted during WAIT_DONE
    done_dly = 12; nack_m = 1'b0;
    load_req(0, 1'b0, 7'h3c, 2'd0, 32'h5555_aaaa);
    req = 2'b01; found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (dbg_state == ST_WAIT_DONE) begin found = 1'b1; break; end
      core_step();
    end
    check("rstmid reached wait_done", {31'h0, found}, 32'h1);
    #2 RST = 1'b1;
    #1;
    check("rstmid gnt", {30'h0, gnt}, 32'h0);
    check("rstmid con1", {24'h0, bus.i2c_con1}, 32'h0);
    check("rstmid Din", bus.Din, 32'h0);
    check("rstmid rdata", rdata, 32'h0);
    req = 2'b00; bus.i2c_stat = STAT_JUNK;
    @(negedge CLK);
    check("rstmid core held", {24'h0, bus.i2c_con1}, 32'h0);
    RST = 1'b0; done_dly = 2;
    @(negedge CLK);
    run_vec("fresh", vt[6]);

    // both requesters held: grants alternate starting from requester 0
    load_req(0, 1'b0, 7'h21, 2'd0, 32'h1111_1111);
    load_req(1, 1'b0, 7'h42, 2'd1, 32'h2222_2222);
    nack_m = 1'b0; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_xfer(1'b1, g, c1, c2, din, dn, er, rd, ok);
      check($sformatf("rr%0d completed", k), {31'h0, ok}, 32'h1);
      check($sformatf("rr%0d gnt", k), {30'h0, g}, (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d done", k), {30'h0, dn}, (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d con2", k), {24'h0, c2}, (k % 2 == 0) ? 32'h21 : 32'h42);
    end
    req = 2'b00;

    // core never raises busy: timeout -> one RECOVER cycle -> done with err
    busy_ok = 1'b0;
    load_req(0, 1'b0, 7'h33, 2'd1, 32'h0000_0001);
    req = 2'b01; ecount = 0; got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (bus.i2c_con1[1]) ecount++;
      else if (!bus.i2c_con1[0]) begin got = 1'b1; break; end
      core_step();
    end
    check("tmo recover seen", {31'h0, got}, 32'h1);
    check("tmo e cycles", ecount, 32'd17);
    check("tmo gnt in recover", {30'h0, gnt}, 32'h1);
    check("tmo e in recover", {31'h0, bus.i2c_con1[1]}, 32'h0);
    @(negedge CLK);
    check("tmo done", {30'h0, done}, 32'h1);
    check("tmo err", {31'h0, err}, 32'h1);
    check("tmo rdata kept", rdata, 32'h0000_0066);
    check("tmo gnt dropped", {30'h0, gnt}, 32'h0);
    check("tmo r released", {31'h0, bus.i2c_con1[0]}, 32'h1);
    req = 2'b00; busy_ok = 1'b1;
    repeat (3) @(negedge CLK);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
